// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command stream to APB requester with per-slave psel and pready timeout
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16,
  localparam int SEL_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_WIDTH-1:0]  req_sel,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_sel_ok;
  logic                    w_timeout;
  logic [NUM_SLAVES-1:0]   w_psel_onehot;

  // Widened compare so the legality check stays meaningful when NUM_SLAVES is a power of two.
  assign w_sel_ok      = ({1'b0, req_sel} < (SEL_WIDTH + 1)'(NUM_SLAVES));
  assign w_timeout     = (TIMEOUT != 0) && (r_cnt == LP_TO_LAST);
  assign w_psel_onehot = NUM_SLAVES'(1) << r_sel;

  assign paddr     = r_addr;
  assign pwrite    = r_write;
  assign pwdata    = r_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake / APB control outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    psel        = '0;
    penable     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_sel_ok ? S_SETUP : S_RESP;
        end
      end
      S_SETUP: begin
        psel        = w_psel_onehot;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = w_psel_onehot;
        penable = 1'b1;
        if (pready || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, wait counter and response capture; pready beats the timeout.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sel   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sel   <= req_sel;
            r_addr  <= req_addr;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= ~w_sel_ok;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          if (pready) begin
            r_rdata <= r_write ? '0 : prdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = '0;
  logic [7:0] req_addr = '0;
  logic       req_write = 1'b0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [2:0] psel;
  logic       penable;
  logic [7:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready_r = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [3][256];

  apb_cmd_master #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready_r)
  );

  always #5 clk = ~clk;

  // Three simple memory slaves on a shared bus.
  always_comb begin
    prdata = 8'h00;
    if (psel[0]) prdata = mem[0][paddr];
    if (psel[1]) prdata = mem[1][paddr];
    if (psel[2]) prdata = mem[2][paddr];
  end

  always @(posedge clk) begin
    if (penable && pready_r && pwrite) begin
      for (int s = 0; s < 3; s++) if (psel[s]) mem[s][paddr] <= pwdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [1:0] s, input logic [7:0] a, input logic w, input logic [7:0] d);
    @(negedge clk);
    req_sel = s; req_addr = a; req_write = w; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Observes n cycles (sampled on negedges), starting with the cycle right after accept.
  task automatic watch(input int n, output int n_setup, output int n_access, output int rsp_at,
                       output logic [2:0] psel_or, output logic [7:0] rd, output logic er);
    n_setup = 0; n_access = 0; rsp_at = -1; psel_or = '0; rd = 'x; er = 1'bx;
    for (int c = 0; c < n; c++) begin
      if (|psel && !penable) n_setup++;
      if (|psel && penable) n_access++;
      psel_or |= psel;
      if (rsp_valid && rsp_at < 0) begin
        rsp_at = c; rd = rsp_rdata; er = rsp_err;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_in_reset: got %b want 1", req_ready); end
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_err, penable, pwrite} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {rsp_valid, rsp_err, penable, pwrite}); end
    n_cmp++; if ({psel, paddr, pwdata, rsp_rdata} !== 27'd0) begin n_err++; $display("FAIL reset_bus: got %h want 0", {psel, paddr, pwdata, rsp_rdata}); end
  endtask

  task automatic test_write();
    int su, ac, at; logic [2:0] po; logic [7:0] rd; logic er;
    send(2'd0, 8'h00, 1'b1, 8'hF0);
    n_cmp++; if ({pwrite, pwdata} !== {1'b1, 8'hF0}) begin n_err++; $display("FAIL write_bus: got %h want 1f0", {pwrite, pwdata}); end
    watch(6, su, ac, at, po, rd, er);
    n_cmp++; if (su !== 1) begin n_err++; $display("FAIL write_setup_cycles: got %0d want 1", su); end
    n_cmp++; if (ac !== 1) begin n_err++; $display("FAIL write_access_cycles: got %0d want 1", ac); end
    n_cmp++; if (po !== 3'b001) begin n_err++; $display("FAIL write_psel: got %b want 001", po); end
    n_cmp++; if (at !== 2) begin n_err++; $display("FAIL write_rsp_latency: got %0d want 2", at); end
    n_cmp++; if ({er, rd} !== 9'h000) begin n_err++; $display("FAIL write_rsp: got err=%b data=%h want err=0 data=00", er, rd); end
  endtask

  task automatic test_read();
    int su, ac, at; logic [2:0] po; logic [7:0] rd; logic er;
    send(2'd1, 8'h00, 1'b1, 8'hE2);
    watch(6, su, ac, at, po, rd, er);
    send(2'd1, 8'h00, 1'b0, 8'h00);
    watch(6, su, ac, at, po, rd, er);
    n_cmp++; if (po !== 3'b010) begin n_err++; $display("FAIL read1_psel: got %b want 010", po); end
    n_cmp++; if (at !== 2) begin n_err++; $display("FAIL read1_latency: got %0d want 2", at); end
    n_cmp++; if ({er, rd} !== {1'b0, 8'hE2}) begin n_err++; $display("FAIL read1_rsp: got err=%b data=%h want err=0 data=e2", er, rd); end
    send(2'd0, 8'h00, 1'b0, 8'h00);
    watch(6, su, ac, at, po, rd, er);
    n_cmp++; if ({er, rd} !== {1'b0, 8'hF0}) begin n_err++; $display("FAIL read0_rsp: got err=%b data=%h want err=0 data=f0", er, rd); end
  endtask

  task automatic test_timeout();
    int su, ac, at; logic [2:0] po; logic [7:0] rd; logic er;
    send(2'd2, 8'h05, 1'b1, 8'h5A);
    watch(6, su, ac, at, po, rd, er);
    pready_r = 1'b0;
    send(2'd2, 8'h05, 1'b0, 8'h00);
    watch(24, su, ac, at, po, rd, er);
    pready_r = 1'b1;
    n_cmp++; if (ac !== 16) begin n_err++; $display("FAIL timeout_access_cycles: got %0d want 16", ac); end
    n_cmp++; if (at !== 17) begin n_err++; $display("FAIL timeout_latency: got %0d want 17", at); end
    n_cmp++; if ({er, rd} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL timeout_rsp: got err=%b data=%h want err=1 data=00", er, rd); end
  endtask

  task automatic test_timeout_edge();
    pready_r = 1'b0;
    send(2'd2, 8'h05, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) @(negedge clk);
    n_cmp++; if ({penable, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL tedge_still_access: got %b want 10", {penable, rsp_valid}); end
    pready_r = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h5A}) begin n_err++; $display("FAIL tedge_rsp: got v/err/data=%b%b/%h want 10/5a", rsp_valid, rsp_err, rsp_rdata); end
    for (int i = 0; i < 3; i++) @(negedge clk);
  endtask

  task automatic test_bad_sel();
    int su, ac, at; logic [2:0] po; logic [7:0] rd; logic er;
    send(2'd3, 8'h11, 1'b0, 8'h00);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata, psel} !== {2'b11, 8'h00, 3'b000}) begin n_err++; $display("FAIL badsel_rsp: got %b want 11_00000000_000", {rsp_valid, rsp_err, rsp_rdata, psel}); end
    watch(4, su, ac, at, po, rd, er);
    n_cmp++; if ({po, su[3:0], ac[3:0]} !== 11'd0) begin n_err++; $display("FAIL badsel_no_apb: got psel_or=%b setup=%0d access=%0d want 0", po, su, ac); end
  endtask

  task automatic test_rsp_hold();
    int held = 0;
    rsp_ready = 1'b0;
    send(2'd0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid === 1'b1 && req_ready === 1'b0 && rsp_rdata === 8'hF0 && rsp_err === 1'b0) held++;
      @(negedge clk);
    end
    n_cmp++; if (held !== 5) begin n_err++; $display("FAIL hold_cycles: got %0d want 5", held); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL hold_release: got %b want 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_reset_access();
    int su, ac, at; logic [2:0] po; logic [7:0] rd; logic er;
    pready_r = 1'b0;
    send(2'd1, 8'h40, 1'b1, 8'h77);
    @(negedge clk);
    n_cmp++; if ({psel, penable} !== 4'b0101) begin n_err++; $display("FAIL rst_pre_access: got %b want 0101", {psel, penable}); end
    #2 arst_n = 1'b0;
    #1;
    n_cmp++; if ({psel, penable, rsp_valid, pwrite} !== 6'd0) begin n_err++; $display("FAIL rst_async_ctrl: got %b want 000000", {psel, penable, rsp_valid, pwrite}); end
    n_cmp++; if ({paddr, pwdata} !== 16'h0000) begin n_err++; $display("FAIL rst_async_bus: got %h want 0000", {paddr, pwdata}); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_ready: got %b want 1", req_ready); end
    @(negedge clk);
    arst_n = 1'b1;
    pready_r = 1'b1;
    watch(6, su, ac, at, po, rd, er);
    n_cmp++; if (at !== -1) begin n_err++; $display("FAIL rst_no_response: got rsp at %0d want none", at); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    @(negedge clk);
    req_sel = 2'd2; req_addr = 8'h07; req_write = 1'b1; req_wdata = 8'h33; req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
    n_cmp++; if (mem[2][7] !== 8'h33) begin n_err++; $display("FAIL b2b_data: got %h want 33", mem[2][7]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_timeout_edge();
    test_bad_sel();
    test_rsp_hold();
    test_reset_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
